// File: rtl/clk_div_gen_if.sv
// clk_div_gen_if: configuration, enable and output bundle for clk_div_gen.
// The optional sync input exists only when CLKDIV_SYNC_EN is defined.
interface clk_div_gen_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic [CHANNELS-1:0] en;
    logic                cfg_valid;
    logic [CHW-1:0]      cfg_ch;
    logic [WIDTH-1:0]    cfg_div;
    logic [WIDTH-1:0]    cfg_high;
    logic                cfg_err;
    logic [CHANNELS-1:0] cfg_pending;
    logic [CHANNELS-1:0] div_out;
    logic [CHANNELS-1:0] tick;
`ifdef CLKDIV_SYNC_EN
    logic                sync;

    modport master (
        output en, cfg_valid, cfg_ch, cfg_div, cfg_high, sync,
        input  cfg_err, cfg_pending, div_out, tick
    );
    modport slave (
        input  en, cfg_valid, cfg_ch, cfg_div, cfg_high, sync,
        output cfg_err, cfg_pending, div_out, tick
    );
`else
    modport master (
        output en, cfg_valid, cfg_ch, cfg_div, cfg_high,
        input  cfg_err, cfg_pending, div_out, tick
    );
    modport slave (
        input  en, cfg_valid, cfg_ch, cfg_div, cfg_high,
        output cfg_err, cfg_pending, div_out, tick
    );
`endif
endinterface

// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel programmable clock/strobe generator.
// Each channel divides the system clock by a programmable period with a
// programmable high time and emits a one-cycle tick at each period start.
// Writes go to a shadow register and are applied only at a period boundary.
// Optional feature: define CLKDIV_SYNC_EN to add a global sync input that
// forces every enabled channel to restart its period on the same edge.
module clk_div_gen #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic         clk,
    input  logic         rst,
    clk_div_gen_if.slave bus
);

    // One extra bit so CHANNELS itself is representable for the range test.
    localparam logic [CHW:0] CH_LIMIT = (CHW + 1)'(CHANNELS);

    logic                chOutOfRange;
    logic                cfgHit;
    logic                syncNow;
    logic                cfgErr_q;
    logic                cfgErr_d;
    logic [CHANNELS-1:0] pendingAll;
    logic [CHANNELS-1:0] divOutAll;
    logic [CHANNELS-1:0] tickAll;

    assign chOutOfRange = ({1'b0, bus.cfg_ch} >= CH_LIMIT);
    assign cfgHit       = bus.cfg_valid && !chOutOfRange;
    assign cfgErr_d     = bus.cfg_valid && chOutOfRange;

`ifdef CLKDIV_SYNC_EN
    assign syncNow = bus.sync;
`else
    assign syncNow = 1'b0;
`endif

    // Out-of-range write flag, a single-cycle pulse after the bad write.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfgErr_q <= 1'b0;
        end else begin
            cfgErr_q <= cfgErr_d;
        end
    end

    assign bus.cfg_err     = cfgErr_q;
    assign bus.cfg_pending = pendingAll;
    assign bus.div_out     = divOutAll;
    assign bus.tick        = tickAll;

    for (genvar i = 0; i < CHANNELS; i++) begin : gChannel
        logic [WIDTH-1:0] divSh_q,   divSh_d;
        logic [WIDTH-1:0] highSh_q,  highSh_d;
        logic [WIDTH-1:0] divAct_q,  divAct_d;
        logic [WIDTH-1:0] highAct_q, highAct_d;
        logic [WIDTH-1:0] ctr_q,     ctr_d;
        logic             pending_q, pending_d;
        logic             divOut_q,  divOut_d;
        logic             tick_q,    tick_d;
        logic             write;
        logic             wrap;
        logic [WIDTH-1:0] lastCount;
        logic [WIDTH-1:0] ctrNext;
        logic [WIDTH-1:0] highEff;

        // Next-state: idle channels track the shadow and park the counter on
        // the last count so enabling starts a fresh period immediately; running
        // channels count and reload the shadow on wrap. A write always lands
        // in the shadow and marks it pending, even on the wrap edge itself.
        always_comb begin
            divSh_d   = divSh_q;
            highSh_d  = highSh_q;
            divAct_d  = divAct_q;
            highAct_d = highAct_q;
            ctr_d     = ctr_q;
            pending_d = pending_q;
            divOut_d  = 1'b0;
            tick_d    = 1'b0;
            highEff   = highAct_q;

            write     = cfgHit && (bus.cfg_ch == CHW'(i));
            lastCount = (divAct_q == '0) ? '0 : divAct_q - 1'b1;
            wrap      = (ctr_q == lastCount) || syncNow;
            ctrNext   = wrap ? '0 : ctr_q + 1'b1;

            if (!bus.en[i]) begin
                divAct_d  = divSh_q;
                highAct_d = highSh_q;
                pending_d = 1'b0;
                ctr_d     = (divSh_q == '0) ? '0 : divSh_q - 1'b1;
            end else begin
                ctr_d = ctrNext;
                if (wrap) begin
                    divAct_d  = divSh_q;
                    highAct_d = highSh_q;
                    pending_d = 1'b0;
                    highEff   = highSh_q;
                    tick_d    = 1'b1;
                end
                divOut_d = (ctrNext < highEff);
            end

            if (write) begin
                divSh_d   = bus.cfg_div;
                highSh_d  = bus.cfg_high;
                pending_d = 1'b1;
            end
        end

        // Channel state and registered outputs; reset restores a div-2 square wave.
        always_ff @(posedge clk) begin
            if (rst) begin
                divSh_q   <= WIDTH'(2);
                highSh_q  <= WIDTH'(1);
                divAct_q  <= WIDTH'(2);
                highAct_q <= WIDTH'(1);
                ctr_q     <= WIDTH'(1);
                pending_q <= 1'b0;
                divOut_q  <= 1'b0;
                tick_q    <= 1'b0;
            end else begin
                divSh_q   <= divSh_d;
                highSh_q  <= highSh_d;
                divAct_q  <= divAct_d;
                highAct_q <= highAct_d;
                ctr_q     <= ctr_d;
                pending_q <= pending_d;
                divOut_q  <= divOut_d;
                tick_q    <= tick_d;
            end
        end

        assign pendingAll[i] = pending_q;
        assign divOutAll[i]  = divOut_q;
        assign tickAll[i]    = tick_q;
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed bench for clk_div_gen with a behavioural model
// feeding a scoreboard queue. Three channels are used so that channel index 3
// is representable and exercises the out-of-range error path.
module tb_clk_div_gen;

    localparam int CHANNELS = 3;
    localparam int WIDTH    = 8;
    localparam int CHW      = 2;

    logic clk = 1'b0;
    logic rst;

    clk_div_gen_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .CHW(CHW)) bus ();

    clk_div_gen #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .CHW(CHW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CHANNELS-1:0] div;
        logic [CHANNELS-1:0] tick;
        logic [CHANNELS-1:0] pend;
        logic                err;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;

    // Model: position within the current period, counted from its start.
    int mDivSh[CHANNELS];
    int mHighSh[CHANNELS];
    int mDivAct[CHANNELS];
    int mHighAct[CHANNELS];
    int mPos[CHANNELS];
    bit mRun[CHANNELS];
    bit mPend[CHANNELS];

    task automatic modelReset();
        for (int i = 0; i < CHANNELS; i++) begin
            mDivSh[i]   = 2;
            mHighSh[i]  = 1;
            mDivAct[i]  = 2;
            mHighAct[i] = 1;
            mPos[i]     = 0;
            mRun[i]     = 1'b0;
            mPend[i]    = 1'b0;
        end
    endtask

    // Drive one cycle of inputs and push the outputs expected after the edge.
    task automatic applyStimulus(input logic r, input logic [CHANNELS-1:0] e,
                                 input logic v, input int ch, input int dv,
                                 input int hi, input logic s);
        exp_t x;
        int   p;
        bit   start;
        x             = '0;
        rst           = r;
        bus.en        = e;
        bus.cfg_valid = v;
        bus.cfg_ch    = CHW'(ch);
        bus.cfg_div   = WIDTH'(dv);
        bus.cfg_high  = WIDTH'(hi);
`ifdef CLKDIV_SYNC_EN
        bus.sync      = s;
`endif
        if (r) begin
            modelReset();
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!e[i]) begin
                    mDivAct[i]  = mDivSh[i];
                    mHighAct[i] = mHighSh[i];
                    mPend[i]    = 1'b0;
                    mRun[i]     = 1'b0;
                end else begin
                    p     = (mDivAct[i] == 0) ? 1 : mDivAct[i];
                    start = !mRun[i] || (mPos[i] == p - 1) || s;
                    if (start) begin
                        mPos[i]     = 0;
                        mDivAct[i]  = mDivSh[i];
                        mHighAct[i] = mHighSh[i];
                        mPend[i]    = 1'b0;
                    end else begin
                        mPos[i]++;
                    end
                    x.div[i]  = (mPos[i] < mHighAct[i]);
                    x.tick[i] = (mPos[i] == 0);
                    mRun[i]   = 1'b1;
                end
                if (v && ch == i) begin
                    mDivSh[i]  = dv;
                    mHighSh[i] = hi;
                    mPend[i]   = 1'b1;
                end
                x.pend[i] = mPend[i];
            end
            x.err = v && (ch >= CHANNELS);
        end
        sbQ.push_back(x);
    endtask

    // Wait past the edge, pop the oldest expectation and compare every output.
    task automatic checkOutput();
        exp_t x;
        @(posedge clk);
        #1;
        checks++;
        assert (sbQ.size() > 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
        end
        if (sbQ.size() > 0) begin
            x = sbQ.pop_front();
            checks++;
            assert (bus.div_out === x.div) else begin
                errors++;
                $error("[TB] FAIL div_out t=%0t observed=%b expected=%b", $time, bus.div_out, x.div);
            end
            checks++;
            assert (bus.tick === x.tick) else begin
                errors++;
                $error("[TB] FAIL tick t=%0t observed=%b expected=%b", $time, bus.tick, x.tick);
            end
            checks++;
            assert (bus.cfg_pending === x.pend) else begin
                errors++;
                $error("[TB] FAIL cfg_pending t=%0t observed=%b expected=%b", $time, bus.cfg_pending, x.pend);
            end
            checks++;
            assert (bus.cfg_err === x.err) else begin
                errors++;
                $error("[TB] FAIL cfg_err t=%0t observed=%b expected=%b", $time, bus.cfg_err, x.err);
            end
        end
    endtask

    task automatic idle(input int n, input logic [CHANNELS-1:0] e);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, e, 1'b0, 0, 0, 0, 1'b0);
            checkOutput();
        end
    endtask

    task automatic wr(input logic [CHANNELS-1:0] e, input int ch, input int dv, input int hi);
        applyStimulus(1'b0, e, 1'b1, ch, dv, hi, 1'b0);
        checkOutput();
    endtask

    // Directed sequence covering the main waveform, reconfiguration and corners.
    initial begin
        modelReset();
        applyStimulus(1'b1, '0, 1'b0, 0, 0, 0, 1'b0);
        checkOutput();
        applyStimulus(1'b1, '0, 1'b0, 0, 0, 0, 1'b0);
        checkOutput();

        idle(6, 3'b001);

        wr(3'b001, 1, 5, 2);
        idle(12, 3'b011);

        idle(2, 3'b011);
        wr(3'b011, 1, 3, 1);
        idle(10, 3'b011);

        wr(3'b011, 3, 9, 9);
        idle(4, 3'b011);

        for (int k = 0; k < 9; k++) begin
            wr(3'b011, 1, 2 + (k % 4), k % 3);
            idle(k % 3, 3'b011);
        end

        idle(2, 3'b000);
        wr(3'b000, 0, 0, 1);
        wr(3'b000, 1, 4, 0);
        wr(3'b000, 2, 4, 7);
        idle(10, 3'b111);

        idle(1, 3'b101);
        idle(6, 3'b111);

`ifdef CLKDIV_SYNC_EN
        wr(3'b000, 0, 4, 1);
        wr(3'b000, 2, 6, 3);
        idle(5, 3'b101);
        applyStimulus(1'b0, 3'b101, 1'b0, 0, 0, 0, 1'b1);
        checkOutput();
        idle(8, 3'b101);
        applyStimulus(1'b0, 3'b101, 1'b1, 0, 2, 1, 1'b1);
        checkOutput();
        idle(8, 3'b101);
`endif

        applyStimulus(1'b1, 3'b111, 1'b1, 1, 7, 3, 1'b0);
        checkOutput();
        idle(5, 3'b011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Multi-channel programmable clock/strobe generator, the parametrised successor to the single-channel toggle divider. Each channel produces a divided waveform with programmable period and high time, plus a one-cycle tick at each period start. Configuration is double-buffered: writes land in a shadow register and take effect only at the next period boundary, so output waveforms never glitch. The block sits beside the sprite pipeline and supplies pixel, line and peripheral strobes from the single system clock.

## Interface
- CHANNELS, 4, number of independent divider channels (1..16).
- WIDTH, 16, counter/config width; maximum period 2^WIDTH-1 cycles.
- CHW, $clog2(CHANNELS) (min 1), channel-index width (derived).

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  CHANNELS  per-channel run enable.
- cfg_valid  in  1  config write strobe; accepted on the same edge (no stall).
- cfg_ch  in  CHW  target channel.
- cfg_div  in  WIDTH  period in cycles; 0 is treated as 1.
- cfg_high  in  WIDTH  cycles high per period.
- cfg_err  out  1  one-cycle pulse: write addressed cfg_ch >= CHANNELS.
- cfg_pending  out  CHANNELS  shadow written but not yet applied.
- div_out  out  CHANNELS  divided waveform (registered).
- tick  out  CHANNELS  one-cycle pulse at each period start (registered).

## Operation
- Per-channel state: shadow {div_sh, high_sh}, active {div_act, high_act}, counter ctr (WIDTH bits), pending flag.
- Reset: div_sh = div_act = 2, high_sh = high_act = 1, ctr = 1, pending = 0. All outputs 0.
- P = max(div_act, 1). ctr counts 0..P-1 and wraps to 0.
- Write, cfg_valid=1 and cfg_ch valid: the shadow of cfg_ch <= {cfg_div, cfg_high}; pending <= 1. Out-of-range cfg_ch: no state change; cfg_err=1 the next cycle.
- Disabled channel, en[i]=0:
  - active continuously copies shadow; pending cleared.
  - ctr <= max(div_sh,1)-1, so the next step wraps.
  - div_out=0, tick=0.
- Enabled channel, per edge: ctr_n = (ctr==P-1) ? 0 : ctr+1.
  - On wrap (ctr_n==0): active <= shadow and pending <= 0. div_out uses the new high_sh; tick <= 1.
  - Otherwise tick <= 0.
  - div_out <= (ctr_n < high_eff), where high_eff is the active value, or the reloaded value on a wrap edge.
- Boundaries:
  - high >= P: div_out constantly 1.
  - high = 0: div_out constantly 0; tick still runs.
  - P = 1: tick and div_out (if high >= 1) held high every cycle.
- Write on the same edge as that channel's wrap: the reload uses the previous shadow. The new value stays pending until the following wrap.
- en dropped mid-period: the channel stops at that edge, and the next enable starts a fresh period.
- rst mid-operation: returns all channels to reset values on that edge; in-flight writes are discarded.

## Timing
- en[i] sampled high at edge N: tick[i]=1 and div_out[i]=(high>0) during cycle N+1; the period is then exactly P cycles, tick spaced P cycles apart.
- Config write at edge N: cfg_pending high from cycle N+1 until the wrap edge that applies it.
- Config latency: at most P_old + 1 cycles from write to the new waveform on an enabled channel.
- cfg_err: single pulse in cycle N+1.
- All outputs are direct flop outputs; no combinational path from inputs to outputs.

## Configuration
- CLKDIV_SYNC_EN defined: adds input sync (1 bit).
  - sync=1 at an edge forces every enabled channel to wrap on that edge: ctr=0, shadow reload, tick=1.
  - Disabled channels ignore it.
  - sync coincident with a config write behaves as a wrap coincident with a write (old shadow applied).
- CLKDIV_SYNC_EN undefined: port absent; channels run only from their own counters.

## Test plan
- Reset, then en=1 on ch0 with no writes -> div_out[0] toggles every cycle (div 2, high 1); tick[0] every 2nd cycle, first tick in the cycle after en.
- Write ch1 div=5 high=2, then enable -> div_out[1] pattern 1,1,0,0,0 repeating; tick[1] every 5 cycles.
- ch1 running div=5; write div=3 high=1 mid-period -> current 5-cycle period completes; cfg_pending[1]=1 until the wrap; then pattern 1,0,0.
- Write with cfg_ch=CHANNELS -> cfg_err single pulse; no channel's shadow changes.
- Corners: div=0, high=0, and high=7 with div=4 -> constant-high tick with div_out high; div_out constant 0 with ticks; div_out constant 1.
- With CLKDIV_SYNC_EN: ch0 div=4 and ch2 div=6 running; pulse sync -> both ticks assert together in the next cycle, then resume their own periods.
